// File: rtl/cp0_exception_pkg.sv
// Shared CP0 register indices, exception codes and field positions for the cp0_exception block.
package cp0_exception_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_TI   = 30;
  localparam int IM_HI      = 15;
  localparam int IM_LO      = 8;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } excCode_e;

  typedef struct packed {
    logic     valid;
    excCode_e code;
    logic     isEret;
    logic     isFetchAde;
  } excResult_t;

  function automatic logic isAddrErr(input excCode_e code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exception_priority.sv
// Combinational exception prioritiser: picks the single highest-priority cause for the MEM instruction.
module cp0_exception_priority
  import cp0_exception_pkg::*;
(
  input  logic       intPending,
  input  logic [1:0] pcLow,
  input  logic       ri,
  input  logic       sys,
  input  logic       brk,
  input  logic       ov,
  input  logic       adeLd,
  input  logic       adeSt,
  input  logic       eret,
  output excResult_t result
);

  // eret only takes effect when nothing of higher priority is pending
  always_comb begin
    result.valid      = 1'b1;
    result.code       = EXC_INT;
    result.isEret     = 1'b0;
    result.isFetchAde = 1'b0;
    if (intPending) begin
      result.code = EXC_INT;
    end else if (pcLow != 2'b00) begin
      result.code       = EXC_ADEL;
      result.isFetchAde = 1'b1;
    end else if (ri) begin
      result.code = EXC_RI;
    end else if (sys) begin
      result.code = EXC_SYS;
    end else if (brk) begin
      result.code = EXC_BP;
    end else if (ov) begin
      result.code = EXC_OV;
    end else if (adeLd) begin
      result.code = EXC_ADEL;
    end else if (adeSt) begin
      result.code = EXC_ADES;
    end else begin
      result.valid  = 1'b0;
      result.isEret = eret;
    end
  end

endmodule

// File: rtl/cp0_exception.sv
// MEM-stage CP0: exception/eret handling, mfc0/mtc0 and the Count/Compare timer.
// Define CP0_TIMER_INT_EN to implement Compare and the timer interrupt (Cause.TI).
module cp0_exception
  import cp0_exception_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallM,
  input  logic [31:0] pcM,
  input  logic        is_in_delayslotM,
  input  logic        riM,
  input  logic        breakM,
  input  logic        syscallM,
  input  logic        eretM,
  input  logic        overflowM,
  input  logic        addr_err_ldM,
  input  logic        addr_err_stM,
  input  logic [31:0] mem_addrM,
  input  logic        cp0_wenM,
  input  logic [4:0]  cp0_addrM,
  input  logic [31:0] cp0_wdataM,
  input  logic [5:0]  ext_int,
  output logic [31:0] cp0_rdataM,
  output logic        flush_excM,
  output logic [31:0] pc_excM,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic [31:0] badVAddr, count, compare, status, cause, epc;
  logic        tick;
  logic        intPending, excCommit, eretCommit, wrCommit, countWrite, tiNext;
  logic [31:0] countNext;
  excResult_t  exc;

  assign intPending = status[STATUS_IE] & ~status[STATUS_EXL]
                    & |(cause[IM_HI:IM_LO] & status[IM_HI:IM_LO]);

  cp0_exception_priority uPriority (
    .intPending (intPending),
    .pcLow      (pcM[1:0]),
    .ri         (riM),
    .sys        (syscallM),
    .brk        (breakM),
    .ov         (overflowM),
    .adeLd      (addr_err_ldM),
    .adeSt      (addr_err_stM),
    .eret       (eretM),
    .result     (exc)
  );

  assign excCommit  = ~stallM & exc.valid;
  assign eretCommit = ~stallM & exc.isEret;
  assign wrCommit   = ~stallM & cp0_wenM & ~exc.valid & ~eretM;
  assign countWrite = wrCommit && (cp0_addrM == CP0_COUNT);

  assign flush_excM = exc.valid | eretM;
  assign pc_excM    = exc.isEret ? epc : EXC_VECTOR;

  // The timer runs freely; only an mtc0 to Count preempts the half-rate increment
  always_comb begin
    countNext = count;
    if (countWrite) begin
      countNext = cp0_wdataM;
    end else if (tick) begin
      countNext = count + 32'd1;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic [31:0] compareReg;
  logic        compareWrite;

  assign compareWrite = wrCommit && (cp0_addrM == CP0_COMPARE);
  assign compare      = compareReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      compareReg <= '0;
    end else if (compareWrite) begin
      compareReg <= cp0_wdataM;
    end
  end

  // Writing Compare acknowledges the timer interrupt and beats a simultaneous match
  always_comb begin
    tiNext = cause[CAUSE_TI];
    if (compareWrite) begin
      tiNext = 1'b0;
    end else if ((countWrite || tick) && (countNext == compare)) begin
      tiNext = 1'b1;
    end
  end
`else
  assign compare = '0;
  assign tiNext  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= STATUS_RST;
      cause    <= '0;
      epc      <= '0;
      badVAddr <= '0;
      count    <= '0;
      tick     <= 1'b0;
    end else begin
      tick             <= ~tick;
      count            <= countNext;
      cause[CAUSE_TI]  <= tiNext;
      cause[15:10]     <= {ext_int[5] | tiNext, ext_int[4:0]};
      if (excCommit) begin
        status[STATUS_EXL] <= 1'b1;
        cause[6:2]         <= exc.code;
        // A nested exception keeps the EPC/BD of the original one
        if (!status[STATUS_EXL]) begin
          epc             <= is_in_delayslotM ? pcM - 32'd4 : pcM;
          cause[CAUSE_BD] <= is_in_delayslotM;
        end
        if (isAddrErr(exc.code)) begin
          badVAddr <= exc.isFetchAde ? pcM : mem_addrM;
        end
      end else if (eretCommit) begin
        status[STATUS_EXL] <= 1'b0;
      end else if (wrCommit) begin
        case (cp0_addrM)
          CP0_STATUS: begin
            status[IM_HI:IM_LO] <= cp0_wdataM[IM_HI:IM_LO];
            status[STATUS_EXL]  <= cp0_wdataM[STATUS_EXL];
            status[STATUS_IE]   <= cp0_wdataM[STATUS_IE];
          end
          CP0_CAUSE: cause[9:8] <= cp0_wdataM[9:8];
          CP0_EPC:   epc        <= cp0_wdataM;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_rdataM = '0;
    case (cp0_addrM)
      CP0_BADVADDR: cp0_rdataM = badVAddr;
      CP0_COUNT:    cp0_rdataM = count;
      CP0_COMPARE:  cp0_rdataM = compare;
      CP0_STATUS:   cp0_rdataM = status;
      CP0_CAUSE:    cp0_rdataM = cause;
      CP0_EPC:      cp0_rdataM = epc;
      default:      cp0_rdataM = '0;
    endcase
  end

  assign status_o = status;
  assign cause_o  = cause;
  assign epc_o    = epc;

endmodule

// File: tb/tb_cp0_exception.sv
// Self-checking bench for cp0_exception: priority table, directed sequences and a randomized run
// against a field-level reference model. Honours CP0_TIMER_INT_EN.
module tb_cp0_exception;

  logic        clk = 1'b0;
  logic        rst, stallM, is_in_delayslotM, riM, breakM, syscallM, eretM, overflowM;
  logic        addr_err_ldM, addr_err_stM, cp0_wenM, flush_excM;
  logic [31:0] pcM, mem_addrM, cp0_wdataM, cp0_rdataM, pc_excM, status_o, cause_o, epc_o;
  logic [4:0]  cp0_addrM;
  logic [5:0]  ext_int;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  cp0_exception dut (
    .clk(clk), .rst(rst), .stallM(stallM), .pcM(pcM), .is_in_delayslotM(is_in_delayslotM),
    .riM(riM), .breakM(breakM), .syscallM(syscallM), .eretM(eretM), .overflowM(overflowM),
    .addr_err_ldM(addr_err_ldM), .addr_err_stM(addr_err_stM), .mem_addrM(mem_addrM),
    .cp0_wenM(cp0_wenM), .cp0_addrM(cp0_addrM), .cp0_wdataM(cp0_wdataM), .ext_int(ext_int),
    .cp0_rdataM(cp0_rdataM), .flush_excM(flush_excM), .pc_excM(pc_excM),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  // Reference model: CP0 state kept as individual architectural fields
  logic        mIE, mEXL, mBD, mTI;
  logic [7:0]  mIM;
  logic [1:0]  mIPsw;
  logic [5:0]  mExt;
  logic [4:0]  mExc;
  logic [31:0] mEPC, mBadV, mCount;
  int          mEdges;
`ifdef CP0_TIMER_INT_EN
  logic [31:0] mCompare;
`endif
  logic        expValid, expFetch;
  logic [4:0]  expCode;

  function automatic logic [31:0] statusWord();
    return {9'b0, 1'b1, 6'b0, mIM, 6'b0, mEXL, mIE};
  endfunction

  function automatic logic [31:0] causeWord();
    return {mBD, mTI, 14'b0, mExt[5] | mTI, mExt[4:0], mIPsw, 1'b0, mExc, 2'b0};
  endfunction

  function automatic logic [31:0] compareWord();
`ifdef CP0_TIMER_INT_EN
    return mCompare;
`else
    return 32'h0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic modelReset();
    mIE = 0; mEXL = 0; mBD = 0; mTI = 0; mIM = '0; mIPsw = '0; mExt = '0; mExc = '0;
    mEPC = '0; mBadV = '0; mCount = '0; mEdges = 0;
`ifdef CP0_TIMER_INT_EN
    mCompare = '0;
`endif
  endtask

  task automatic modelEval();
    logic [7:0] ip;
    logic       conds [8];
    logic [4:0] codes [8];
    ip    = {mExt[5] | mTI, mExt[4:0], mIPsw};
    conds = '{mIE && !mEXL && ((ip & mIM) != 8'h0), pcM[1:0] != 2'b00, riM, syscallM,
              breakM, overflowM, addr_err_ldM, addr_err_stM};
    codes = '{5'h00, 5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05};
    expValid = 0; expCode = '0; expFetch = 0;
    for (int i = 0; i < 8; i++) begin
      if (conds[i] && !expValid) begin
        expValid = 1; expCode = codes[i]; expFetch = (i == 1);
      end
    end
  endtask

  task automatic modelCheck();
    logic [31:0] expRd;
    modelEval();
    case (cp0_addrM)
      5'd8:    expRd = mBadV;
      5'd9:    expRd = mCount;
      5'd11:   expRd = compareWord();
      5'd12:   expRd = statusWord();
      5'd13:   expRd = causeWord();
      5'd14:   expRd = mEPC;
      default: expRd = 32'h0;
    endcase
    checkOutput("flush", {31'b0, flush_excM}, {31'b0, expValid | eretM});
    checkOutput("pcExc", pc_excM, (eretM && !expValid) ? mEPC : 32'hBFC0_0380);
    checkOutput("rdata", cp0_rdataM, expRd);
    checkOutput("status", status_o, statusWord());
    checkOutput("cause", cause_o, causeWord());
    checkOutput("epc", epc_o, mEPC);
  endtask

  task automatic modelAdvance();
    logic wrOk, countWr, stepped;
    modelEval();
    wrOk    = !stallM && !expValid && !eretM && cp0_wenM;
    countWr = wrOk && (cp0_addrM == 5'd9);
    if (!stallM && expValid) begin
      if (!mEXL) begin
        mEPC = is_in_delayslotM ? pcM - 32'd4 : pcM;
        mBD  = is_in_delayslotM;
      end
      mEXL = 1; mExc = expCode;
      if (expCode == 5'h04 || expCode == 5'h05) mBadV = expFetch ? pcM : mem_addrM;
    end else if (!stallM && eretM) begin
      mEXL = 0;
    end else if (wrOk) begin
      case (cp0_addrM)
        5'd12: begin mIM = cp0_wdataM[15:8]; mEXL = cp0_wdataM[1]; mIE = cp0_wdataM[0]; end
        5'd13: mIPsw = cp0_wdataM[9:8];
        5'd14: mEPC = cp0_wdataM;
        default: ;
      endcase
    end
    stepped = (mEdges % 2) == 1;
    if (countWr) mCount = cp0_wdataM;
    else if (stepped) mCount = mCount + 32'd1;
`ifdef CP0_TIMER_INT_EN
    if (wrOk && cp0_addrM == 5'd11) begin
      mCompare = cp0_wdataM; mTI = 0;
    end else if ((countWr || stepped) && mCount == mCompare) begin
      mTI = 1;
    end
`endif
    mExt = ext_int;
    mEdges++;
  endtask

  task automatic applyStimulus();
    #1;
    modelCheck();
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    stallM = 0; is_in_delayslotM = 0; riM = 0; breakM = 0; syscallM = 0; eretM = 0;
    overflowM = 0; addr_err_ldM = 0; addr_err_stM = 0; cp0_wenM = 0;
    pcM = 32'h0000_0400; mem_addrM = '0; cp0_addrM = 5'd12; cp0_wdataM = '0; ext_int = '0;
  endtask

  task automatic doReset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    modelReset();
  endtask

  typedef struct {
    logic       ri, sys, brk, ov, adl, ads, eret;
    logic [1:0] pcLow;
    logic       expFlush, expExc;
    logic [4:0] expCode;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] r;
    vecs[0] = '{1, 1, 1, 0, 0, 0, 0, 2'b00, 1, 1, 5'h0a};
    vecs[1] = '{0, 1, 1, 1, 0, 0, 0, 2'b00, 1, 1, 5'h08};
    vecs[2] = '{0, 0, 1, 1, 0, 0, 0, 2'b00, 1, 1, 5'h09};
    vecs[3] = '{0, 0, 0, 1, 1, 0, 0, 2'b00, 1, 1, 5'h0c};
    vecs[4] = '{0, 0, 0, 0, 1, 1, 0, 2'b00, 1, 1, 5'h04};
    vecs[5] = '{0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 1, 5'h05};
    vecs[6] = '{1, 0, 0, 0, 0, 0, 0, 2'b10, 1, 1, 5'h04};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 5'h00};
    vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 5'h00};
    vecs[9] = '{1, 0, 0, 0, 0, 0, 1, 2'b00, 1, 1, 5'h0a};

    clearInputs();
    doReset();
    #1;
    checkOutput("rstStatus", status_o, 32'h0040_0000);
    checkOutput("rstCause", cause_o, 32'h0);
    checkOutput("rstEpc", epc_o, 32'h0);
    checkOutput("rstFlush", {31'b0, flush_excM}, 32'h0);

    // Priority table
    cp0_addrM = 5'd8;
    for (int i = 0; i < 10; i++) begin
      riM = vecs[i].ri; syscallM = vecs[i].sys; breakM = vecs[i].brk; overflowM = vecs[i].ov;
      addr_err_ldM = vecs[i].adl; addr_err_stM = vecs[i].ads; eretM = vecs[i].eret;
      pcM = 32'h0000_0400 | {30'b0, vecs[i].pcLow}; mem_addrM = 32'h0000_5000 + i;
      #1;
      checkOutput("tblFlush", {31'b0, flush_excM}, {31'b0, vecs[i].expFlush});
      applyStimulus();
      clearInputs();
      cp0_addrM = 5'd8;
      if (vecs[i].expExc) begin
        checkOutput("tblCode", {27'b0, cause_o[6:2]}, {27'b0, vecs[i].expCode});
        eretM = 1;
        applyStimulus();
        eretM = 0;
      end
    end

    // RI at a boot-ROM address
    pcM = 32'hBFC0_0100; riM = 1;
    #1;
    checkOutput("t1Flush", {31'b0, flush_excM}, 32'h1);
    checkOutput("t1PcExc", pc_excM, 32'hBFC0_0380);
    applyStimulus();
    riM = 0;
    checkOutput("t1Epc", epc_o, 32'hBFC0_0100);
    checkOutput("t1Code", {27'b0, cause_o[6:2]}, 32'h0a);
    checkOutput("t1Exl", {31'b0, status_o[1]}, 32'h1);
    eretM = 1;
    applyStimulus();
    eretM = 0;

    // syscall in a delay slot, then eret back to the branch
    pcM = 32'h80; syscallM = 1; is_in_delayslotM = 1;
    applyStimulus();
    syscallM = 0; is_in_delayslotM = 0;
    checkOutput("t2Epc", epc_o, 32'h7C);
    checkOutput("t2Bd", {31'b0, cause_o[31]}, 32'h1);
    eretM = 1;
    #1;
    checkOutput("t2PcExc", pc_excM, 32'h7C);
    applyStimulus();
    eretM = 0;
    checkOutput("t2Exl", {31'b0, status_o[1]}, 32'h0);

    // Interrupt enable then stall across the pending interrupt
    pcM = 32'h100; cp0_wenM = 1; cp0_addrM = 5'd12; cp0_wdataM = 32'h0000_FF01; ext_int = 6'b000010;
    applyStimulus();
    cp0_wenM = 0;
    #1;
    checkOutput("t3Flush", {31'b0, flush_excM}, 32'h1);
    stallM = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t3StallEpc", epc_o, 32'h7C);
      checkOutput("t3StallCode", {27'b0, cause_o[6:2]}, 32'h08);
    end
    stallM = 0;
    applyStimulus();
    checkOutput("t3Code", {27'b0, cause_o[6:2]}, 32'h0);
    checkOutput("t3Epc", epc_o, 32'h100);
    checkOutput("t3Bd", {31'b0, cause_o[31]}, 32'h0);
    cp0_wenM = 1; cp0_wdataM = 32'h0; ext_int = '0;
    applyStimulus();
    cp0_wenM = 0;

    // Address errors and their ranking against RI
    cp0_addrM = 5'd8; addr_err_ldM = 1; mem_addrM = 32'h1003;
    applyStimulus();
    checkOutput("t4BadV", cp0_rdataM, 32'h1003);
    checkOutput("t4CodeLd", {27'b0, cause_o[6:2]}, 32'h04);
    addr_err_ldM = 0; addr_err_stM = 1; mem_addrM = 32'h2002;
    applyStimulus();
    checkOutput("t4CodeSt", {27'b0, cause_o[6:2]}, 32'h05);
    addr_err_stM = 0; addr_err_ldM = 1; riM = 1; mem_addrM = 32'h3001;
    applyStimulus();
    checkOutput("t4CodeRi", {27'b0, cause_o[6:2]}, 32'h0a);
    checkOutput("t4BadVKeep", cp0_rdataM, 32'h2002);
    addr_err_ldM = 0; riM = 0; eretM = 1;
    applyStimulus();
    eretM = 0;

    // Count wrap and Compare match
    cp0_wenM = 1; cp0_addrM = 5'd9; cp0_wdataM = 32'hFFFF_FFFF;
    applyStimulus();
    cp0_wenM = 0;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("t5Wrap", cp0_rdataM, 32'h0);
    cp0_wenM = 1; cp0_addrM = 5'd11; cp0_wdataM = 32'd10;
    applyStimulus();
    cp0_addrM = 5'd9; cp0_wdataM = 32'd8;
    applyStimulus();
    cp0_wenM = 0; cp0_addrM = 5'd11;
    for (int i = 0; i < 4; i++) applyStimulus();
`ifdef CP0_TIMER_INT_EN
    checkOutput("t5Compare", cp0_rdataM, 32'd10);
    checkOutput("t5TiSet", {31'b0, cause_o[30]}, 32'h1);
    cp0_wenM = 1; cp0_wdataM = 32'd10;
    applyStimulus();
    cp0_wenM = 0;
    checkOutput("t5TiClr", {31'b0, cause_o[30]}, 32'h0);
`else
    checkOutput("t5Compare", cp0_rdataM, 32'h0);
    checkOutput("t5TiOff", {31'b0, cause_o[30]}, 32'h0);
`endif

    // mtc0 EPC discarded by a break in the same instruction
    pcM = 32'h200; breakM = 1; cp0_wenM = 1; cp0_addrM = 5'd14; cp0_wdataM = 32'h1234_5678;
    applyStimulus();
    breakM = 0; cp0_wenM = 0;
    checkOutput("t6Epc", epc_o, 32'h200);
    checkOutput("t6Code", {27'b0, cause_o[6:2]}, 32'h09);

    // Reset with an exception pending
    riM = 1; cp0_addrM = 5'd8;
    doReset();
    riM = 0;
    #1;
    checkOutput("t6RstStatus", status_o, 32'h0040_0000);
    checkOutput("t6RstCause", cause_o, 32'h0);
    checkOutput("t6RstEpc", epc_o, 32'h0);
    checkOutput("t6RstBadV", cp0_rdataM, 32'h0);

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] idx [8];
      idx = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd3};
      r = $urandom();
      pcM = {r[31:2], ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00};
      mem_addrM = $urandom();
      stallM = ($urandom_range(0, 3) == 0);
      is_in_delayslotM = $urandom_range(0, 1);
      riM = ($urandom_range(0, 15) == 0); breakM = ($urandom_range(0, 15) == 0);
      syscallM = ($urandom_range(0, 15) == 0); eretM = ($urandom_range(0, 7) == 0);
      overflowM = ($urandom_range(0, 15) == 0); addr_err_ldM = ($urandom_range(0, 15) == 0);
      addr_err_stM = ($urandom_range(0, 15) == 0);
      cp0_wenM = ($urandom_range(0, 3) == 0);
      cp0_addrM = idx[$urandom_range(0, 7)];
      cp0_wdataM = $urandom();
      ext_int = ($urandom_range(0, 1) == 0) ? 6'b0 : 6'($urandom());
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
